// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int INSTR_W = 16;
   localparam logic [4:0] HALT_OPC_DEF = 5'b00000;
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0800;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      WAIT   = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   function automatic logic is_halt(input logic [INSTR_W-1:0] word, input logic [4:0] opc);
      return word[INSTR_W-1:INSTR_W-5] == opc;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, PCPlus2} holding register used while decode stalls.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr,
   input  logic [INSTR_W-1:0] wr_instr,
   input  logic [15:0]        wr_pc2,
   input  logic               rd,
   input  logic               clr,
   output logic               full,
   output logic [INSTR_W-1:0] rd_instr,
   output logic [15:0]        rd_pc2
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full     <= 1'b0;
         rd_instr <= '0;
         rd_pc2   <= '0;
      end else if (clr) begin
         full <= 1'b0;
      end else if (wr) begin
         full     <= 1'b1;
         rd_instr <= wr_instr;
         rd_pc2   <= wr_pc2;
      end else if (rd) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to a stalling instruction memory
// and fills the IF/ID register, with a skid entry for decode stalls.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0]        RESET_PC  = 16'h0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter logic [4:0]         HALT_OPC  = HALT_OPC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [15:0]        redirectPC,
   output logic               imemReq,
   output logic [15:0]        imemAddr,
   input  logic               imemStall,
   input  logic               imemDone,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instr,
   output logic [15:0]        PCPlus2,
   output logic               instrValid,
   output logic               halted,
   output logic               err
);

   fetch_state_e state, state_n;
   logic [15:0]        pc, pc_n, pc_inc;
   logic               kill, kill_n;
   logic [INSTR_W-1:0] instr_n;
   logic [15:0]        pc2_n;
   logic               valid_n;
   logic               consume, loadable, accept;
   logic               buf_wr, buf_rd, buf_clr, buf_full;
   logic [INSTR_W-1:0] buf_instr;
   logic [15:0]        buf_pc2;

   assign pc_inc   = pc + 16'd2;
   assign consume  = instrValid & ~stall;
   assign loadable = ~instrValid | consume;
   assign imemReq  = (state == FETCH) & ~redirect & ~rst;
   assign imemAddr = pc;
   assign accept   = imemReq & ~imemStall;
   assign halted   = (state == HALTED);

   always_comb begin
      state_n = state;
      pc_n    = pc;
      kill_n  = kill;
      instr_n = instr;
      pc2_n   = PCPlus2;
      valid_n = instrValid;
      buf_wr  = 1'b0;
      buf_rd  = 1'b0;
      buf_clr = 1'b0;

      if (consume) begin
         valid_n = 1'b0;
         instr_n = NOP_INSTR;
      end

      if (redirect) begin
         pc_n    = redirectPC;
         valid_n = 1'b0;
         instr_n = NOP_INSTR;
         buf_clr = 1'b1;
         // A read still in flight must be dropped when it eventually returns.
         if (state == WAIT && !imemDone) begin
            state_n = WAIT;
            kill_n  = 1'b1;
         end else begin
            state_n = FETCH;
            kill_n  = 1'b0;
         end
      end else begin
         case (state)
            FETCH: if (accept) state_n = WAIT;
            WAIT: begin
               if (imemDone) begin
                  if (kill) begin
                     kill_n  = 1'b0;
                     state_n = FETCH;
                  end else if (loadable) begin
                     instr_n = imemData;
                     pc2_n   = pc_inc;
                     valid_n = 1'b1;
                     pc_n    = pc_inc;
                     state_n = is_halt(imemData, HALT_OPC) ? HALTED : FETCH;
                  end else begin
                     buf_wr  = 1'b1;
                     pc_n    = pc_inc;
                     state_n = HOLD;
                  end
               end
            end
            HOLD: begin
               if (loadable && buf_full) begin
                  instr_n = buf_instr;
                  pc2_n   = buf_pc2;
                  valid_n = 1'b1;
                  buf_rd  = 1'b1;
                  state_n = is_halt(buf_instr, HALT_OPC) ? HALTED : FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         kill       <= 1'b0;
         instr      <= NOP_INSTR;
         PCPlus2    <= 16'h0000;
         instrValid <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         kill       <= kill_n;
         instr      <= instr_n;
         PCPlus2    <= pc2_n;
         instrValid <= valid_n;
         // Read data can only legitimately arrive while a request is outstanding.
         if (imemDone && state != WAIT) err <= 1'b1;
      end
   end

   fetch_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .wr       (buf_wr),
      .wr_instr (imemData),
      .wr_pc2   (pc_inc),
      .rd       (buf_rd),
      .clr      (buf_clr),
      .full     (buf_full),
      .rd_instr (buf_instr),
      .rd_pc2   (buf_pc2)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, reset/err sequences, then random
// traffic checked against a sequential instruction-stream model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, redirect = 1'b0;
   logic [15:0] redirectPC = '0;
   logic        imemReq;
   logic [15:0] imemAddr;
   logic        imemStall = 1'b0, imemDone = 1'b0;
   logic [15:0] imemData = '0;
   logic [15:0] instr, PCPlus2;
   logic        instrValid, halted, err;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemStall(imemStall), .imemDone(imemDone),
      .imemData(imemData), .instr(instr), .PCPlus2(PCPlus2), .instrValid(instrValid),
      .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_instr"}, instr, 16'h0800);
      chk({tag, "_pc2"}, PCPlus2, 16'h0000);
      chk({tag, "_valid"}, instrValid, 1'b0);
      chk({tag, "_halted"}, halted, 1'b0);
      chk({tag, "_addr"}, imemAddr, 16'h0000);
   endtask

   typedef struct {
      logic        stall, redir;
      logic [15:0] rpc;
      logic        mstall, done;
      logic [15:0] data;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_instr, e_pc2;
      logic        e_halted;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic s, input logic r, input logic [15:0] rpc, input logic ms,
                      input logic d, input logic [15:0] dat, input logic e_req,
                      input logic [15:0] e_addr, input logic e_valid, input logic [15:0] e_instr,
                      input logic [15:0] e_pc2, input logic e_halted);
      vec_t v;
      v.stall = s; v.redir = r; v.rpc = rpc; v.mstall = ms; v.done = d; v.data = dat;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
      v.e_pc2 = e_pc2; v.e_halted = e_halted;
      vq.push_back(v);
   endtask

   // Random-phase memory and reference model state
   logic [15:0] mem_arr [256];
   logic        mem_busy;
   int          mem_cnt;
   logic [15:0] mem_addr;
   logic [31:0] exp_q[$];
   logic [15:0] nxt_addr;
   logic        exp_halt;
   int          n_consumed;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return mem_arr[a[8:1]];
   endfunction

   task automatic push_next();
      exp_q.push_back({mem_word(nxt_addr), 16'(nxt_addr + 16'd2)});
      nxt_addr = nxt_addr + 16'd2;
   endtask

   task automatic restart(input logic [15:0] target);
      exp_q.delete();
      nxt_addr = target;
      exp_halt = 1'b0;
      for (int k = 0; k < 4; k++) push_next();
   endtask

   initial begin
      // ---------------- reset state ----------------
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", imemReq, 1'b0);
      chk("rst_err", err, 1'b0);
      chk_reset_outputs("rst");

      // ---------------- directed cycle table ----------------
      //   stall redir rpc     mst done data      req addr    vld instr    pc2      hlt
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0);
      add(0, 0, 16'h0000, 0, 1, 16'hC001, 0, 16'h0000, 0, 16'h0800, 16'h0000, 0);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'hC001, 16'h0002, 0);
      add(0, 0, 16'h0000, 0, 1, 16'hC102, 0, 16'h0002, 0, 16'h0800, 16'h0002, 0);
      add(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'hC102, 16'h0004, 0);
      add(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0800, 16'h0004, 0);
      add(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0800, 16'h0004, 0);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0800, 16'h0004, 0);
      add(1, 0, 16'h0000, 0, 1, 16'hC203, 0, 16'h0004, 0, 16'h0800, 16'h0004, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'hC203, 16'h0006, 0);
      add(1, 0, 16'h0000, 0, 1, 16'hC304, 0, 16'h0006, 1, 16'hC203, 16'h0006, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0008, 1, 16'hC203, 16'h0006, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0008, 1, 16'hC203, 16'h0006, 0);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0008, 1, 16'hC203, 16'h0006, 0);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'hC304, 16'h0008, 0);
      add(0, 1, 16'h0040, 0, 0, 16'h0000, 0, 16'h0008, 0, 16'h0800, 16'h0008, 0);
      add(0, 0, 16'h0000, 0, 1, 16'hC405, 0, 16'h0040, 0, 16'h0800, 16'h0008, 0);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0800, 16'h0008, 0);
      add(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0040, 0, 16'h0800, 16'h0008, 0);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0042, 1, 16'h0000, 16'h0042, 1);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0042, 0, 16'h0800, 16'h0042, 1);
      add(0, 1, 16'h0010, 0, 0, 16'h0000, 0, 16'h0042, 0, 16'h0800, 16'h0042, 1);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010, 0, 16'h0800, 16'h0042, 0);
      add(0, 0, 16'h0000, 0, 1, 16'hC506, 0, 16'h0010, 0, 16'h0800, 16'h0042, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0012, 1, 16'hC506, 16'h0012, 0);
      add(0, 1, 16'hFFFE, 0, 0, 16'h0000, 0, 16'h0012, 1, 16'hC506, 16'h0012, 0);
      add(0, 0, 16'h0000, 0, 1, 16'hC607, 0, 16'hFFFE, 0, 16'h0800, 16'h0012, 0);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h0800, 16'h0012, 0);
      add(0, 0, 16'h0000, 0, 1, 16'hC708, 0, 16'hFFFE, 0, 16'h0800, 16'h0012, 0);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hC708, 16'h0000, 0);

      rst = 1'b0;
      for (int i = 0; i < vq.size(); i++) begin
         stall = vq[i].stall; redirect = vq[i].redir; redirectPC = vq[i].rpc;
         imemStall = vq[i].mstall; imemDone = vq[i].done; imemData = vq[i].data;
         #1;
         chk($sformatf("row%0d_req", i), imemReq, vq[i].e_req);
         chk($sformatf("row%0d_addr", i), imemAddr, vq[i].e_addr);
         chk($sformatf("row%0d_valid", i), instrValid, vq[i].e_valid);
         chk($sformatf("row%0d_instr", i), instr, vq[i].e_instr);
         chk($sformatf("row%0d_pc2", i), PCPlus2, vq[i].e_pc2);
         chk($sformatf("row%0d_halted", i), halted, vq[i].e_halted);
         chk($sformatf("row%0d_err", i), err, 1'b0);
         tick();
      end

      // ---------------- reset while a read is outstanding ----------------
      stall = 1'b0; redirect = 1'b0; imemStall = 1'b0;
      rst = 1'b1; imemDone = 1'b1; imemData = 16'hC809;
      #1;
      chk("midwait_req", imemReq, 1'b0);
      chk_reset_outputs("midwait");
      tick();
      imemDone = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("postrst_err", err, 1'b0);
      chk("postrst_req", imemReq, 1'b1);
      chk_reset_outputs("postrst");

      // ---------------- spurious Done in FETCH ----------------
      imemStall = 1'b1;
      tick();
      imemDone = 1'b1;
      tick();
      imemDone = 1'b0;
      #1;
      chk("spurious_err", err, 1'b1);
      chk("spurious_addr", imemAddr, 16'h0000);
      tick();
      chk("err_sticky", err, 1'b1);
      rst = 1'b1;
      #1;
      chk("err_cleared", err, 1'b0);
      tick();

      // ---------------- random traffic ----------------
      for (int i = 0; i < 256; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if ($urandom_range(0, 39) == 0) w[15:11] = 5'd0;
         else if (w[15:11] == 5'd0) w[15:11] = 5'd1;
         mem_arr[i] = w;
      end
      mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; n_consumed = 0;
      restart(16'h0000);
      rst = 1'b0; imemStall = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         imemDone  = mem_busy && (mem_cnt == 0);
         imemData  = imemDone ? mem_word(mem_addr) : 16'($urandom);
         imemStall = ($urandom_range(0, 3) == 0);
         stall     = ($urandom_range(0, 2) == 0);
         redirect  = ($urandom_range(0, 29) == 0);
         redirectPC = ($urandom_range(0, 7) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
         #1;
         if (instrValid && !stall) begin
            logic [31:0] e;
            n_consumed++;
            if (exp_halt) chk("consume_after_halt", 1'b1, 1'b0);
            else begin
               e = exp_q.pop_front();
               chk("rand_instr", instr, e[31:16]);
               chk("rand_pc2", PCPlus2, e[15:0]);
               if (e[31:27] == 5'd0) exp_halt = 1'b1;
               push_next();
            end
         end
         if (exp_halt) begin
            chk("rand_halted", halted, 1'b1);
            chk("rand_halt_noreq", imemReq, 1'b0);
         end
         if (mem_busy) chk("one_outstanding", imemReq, 1'b0);
         chk("rand_err", err, 1'b0);
         if (redirect) restart(redirectPC);
         if (imemDone) mem_busy = 1'b0;
         else if (mem_busy) mem_cnt--;
         if (imemReq && !imemStall) begin
            mem_busy = 1'b1;
            mem_addr = imemAddr;
            mem_cnt  = $urandom_range(0, 2);
         end
         tick();
      end
      chk("rand_progress", 16'(n_consumed > 200), 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
